// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings for the decode/register-file stage: instruction codes,
// register specifiers, status codes and the per-icode register-specifier decode.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'd0;
  localparam logic [3:0] I_NOP    = 4'd1;
  localparam logic [3:0] I_RRMOVQ = 4'd2;
  localparam logic [3:0] I_IRMOVQ = 4'd3;
  localparam logic [3:0] I_RMMOVQ = 4'd4;
  localparam logic [3:0] I_MRMOVQ = 4'd5;
  localparam logic [3:0] I_OPQ    = 4'd6;
  localparam logic [3:0] I_JXX    = 4'd7;
  localparam logic [3:0] I_CALL   = 4'd8;
  localparam logic [3:0] I_RET    = 4'd9;
  localparam logic [3:0] I_PUSHQ  = 4'd10;
  localparam logic [3:0] I_POPQ   = 4'd11;

  localparam logic [3:0] R_NONE = 4'hF;
  localparam logic [3:0] R_RSP  = 4'h4;

  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_HLT = 3'd2;
  localparam logic [2:0] S_ADR = 3'd3;
  localparam logic [2:0] S_INS = 3'd4;

  typedef struct packed {
    logic [3:0] src_a;
    logic [3:0] src_b;
    logic [3:0] dst_e;
    logic [3:0] dst_m;
  } dec_regs_t;

  function automatic dec_regs_t decode_regs(input logic [3:0] icode,
                                            input logic [3:0] ra,
                                            input logic [3:0] rb);
    dec_regs_t d;
    d = '{R_NONE, R_NONE, R_NONE, R_NONE};
    case (icode)
      I_RRMOVQ: d = '{ra,     R_NONE, rb,     R_NONE};
      I_IRMOVQ: d = '{R_NONE, R_NONE, rb,     R_NONE};
      I_RMMOVQ: d = '{ra,     rb,     R_NONE, R_NONE};
      I_MRMOVQ: d = '{R_NONE, rb,     R_NONE, ra};
      I_OPQ:    d = '{ra,     rb,     rb,     R_NONE};
      I_CALL:   d = '{R_NONE, R_RSP,  R_RSP,  R_NONE};
      I_RET:    d = '{R_RSP,  R_RSP,  R_RSP,  R_NONE};
      I_PUSHQ:  d = '{ra,     R_RSP,  R_RSP,  R_NONE};
      I_POPQ:   d = '{R_RSP,  R_RSP,  R_RSP,  ra};
      default:  d = '{R_NONE, R_NONE, R_NONE, R_NONE};
    endcase
    return d;
  endfunction

endpackage

// File: rtl/regfile_2w2r.sv
// Architectural register file: two synchronous write ports (M beats E on the same
// index) and two combinational read ports; specifier 15 reads as zero.
module regfile_2w2r
  import y86_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int NUM_REG    = 15,
  parameter int STACK_INIT = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        i_wr_e_idx,
  input  logic [DATA_W-1:0] i_wr_e_val,
  input  logic [3:0]        i_wr_m_idx,
  input  logic [DATA_W-1:0] i_wr_m_val,
  input  logic [3:0]        i_rd_a_idx,
  input  logic [3:0]        i_rd_b_idx,
  output logic [DATA_W-1:0] o_rd_a_val,
  output logic [DATA_W-1:0] o_rd_b_val
);

  logic [DATA_W-1:0] r_regs [NUM_REG];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REG; i++) begin
      if (reset) begin
        r_regs[i] <= (4'(i) == R_RSP) ? DATA_W'(STACK_INIT) : '0;
      end else if (i_wr_m_idx == 4'(i)) begin
        r_regs[i] <= i_wr_m_val;
      end else if (i_wr_e_idx == 4'(i)) begin
        r_regs[i] <= i_wr_e_val;
      end
    end
  end

  always_comb begin
    o_rd_a_val = '0;
    o_rd_b_val = '0;
    if (i_rd_a_idx < 4'(NUM_REG)) o_rd_a_val = r_regs[i_rd_a_idx];
    if (i_rd_b_idx < 4'(NUM_REG)) o_rd_b_val = r_regs[i_rd_b_idx];
  end

endmodule

// File: rtl/decode_regfile_stage.sv
// Y86-64 decode stage: register specifier decode, forwarding into valA/valB,
// load-use stall detection and the D->E pipeline register.
module decode_regfile_stage
  import y86_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int NUM_REG    = 15,
  parameter int STACK_INIT = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        D_icode,
  input  logic [3:0]        D_ifun,
  input  logic [3:0]        D_rA,
  input  logic [3:0]        D_rB,
  input  logic [2:0]        D_stat,
  input  logic [DATA_W-1:0] D_valC,
  input  logic [DATA_W-1:0] D_valP,
  input  logic [3:0]        e_dstE,
  input  logic [DATA_W-1:0] e_valE,
  input  logic [3:0]        M_dstE,
  input  logic [DATA_W-1:0] M_valE,
  input  logic [3:0]        M_dstM,
  input  logic [DATA_W-1:0] m_valM,
  input  logic [3:0]        W_dstE,
  input  logic [DATA_W-1:0] W_valE,
  input  logic [3:0]        W_dstM,
  input  logic [DATA_W-1:0] W_valM,
  input  logic              E_bubble,
  output logic              d_stall,
  output logic [3:0]        E_icode,
  output logic [3:0]        E_ifun,
  output logic [2:0]        E_stat,
  output logic [DATA_W-1:0] E_valC,
  output logic [DATA_W-1:0] E_valA,
  output logic [DATA_W-1:0] E_valB,
  output logic [3:0]        E_dstE,
  output logic [3:0]        E_dstM
);

  dec_regs_t         w_dec;
  logic [DATA_W-1:0] w_rf_a;
  logic [DATA_W-1:0] w_rf_b;
  logic [DATA_W-1:0] w_val_a;
  logic [DATA_W-1:0] w_val_b;
  logic              w_load_bubble;

  logic [3:0]        r_e_icode_p1;
  logic [3:0]        r_e_ifun_p1;
  logic [2:0]        r_e_stat_p1;
  logic [DATA_W-1:0] r_e_valc_p1;
  logic [DATA_W-1:0] r_e_vala_p1;
  logic [DATA_W-1:0] r_e_valb_p1;
  logic [3:0]        r_e_dste_p1;
  logic [3:0]        r_e_dstm_p1;

  // Youngest producer wins; the register file value is used only when no
  // in-flight instruction targets the source.
  function automatic logic [DATA_W-1:0] sel_fwd(input logic [3:0]        src,
                                                input logic [DATA_W-1:0] rf_val);
    logic [DATA_W-1:0] v;
    if (src == R_NONE)      v = '0;
    else if (src == e_dstE) v = e_valE;
    else if (src == M_dstM) v = m_valM;
    else if (src == M_dstE) v = M_valE;
    else if (src == W_dstM) v = W_valM;
    else if (src == W_dstE) v = W_valE;
    else                    v = rf_val;
    return v;
  endfunction

  regfile_2w2r #(
    .DATA_W     (DATA_W),
    .NUM_REG    (NUM_REG),
    .STACK_INIT (STACK_INIT)
  ) u_regfile (
    .clk        (clk),
    .reset      (reset),
    .i_wr_e_idx (W_dstE),
    .i_wr_e_val (W_valE),
    .i_wr_m_idx (W_dstM),
    .i_wr_m_val (W_valM),
    .i_rd_a_idx (w_dec.src_a),
    .i_rd_b_idx (w_dec.src_b),
    .o_rd_a_val (w_rf_a),
    .o_rd_b_val (w_rf_b)
  );

  // ---- Stage p0: decode, operand selection, hazard detection ----
  always_comb begin
    w_dec   = decode_regs(D_icode, D_rA, D_rB);
    w_val_a = sel_fwd(w_dec.src_a, w_rf_a);
    if (D_icode == I_JXX || D_icode == I_CALL) w_val_a = D_valP;
    w_val_b = sel_fwd(w_dec.src_b, w_rf_b);
  end

  always_comb begin
    d_stall = 1'b0;
    if ((r_e_icode_p1 == I_MRMOVQ || r_e_icode_p1 == I_POPQ) && r_e_dstm_p1 != R_NONE &&
        (r_e_dstm_p1 == w_dec.src_a || r_e_dstm_p1 == w_dec.src_b))
      d_stall = 1'b1;
  end

  assign w_load_bubble = reset || E_bubble || d_stall;

  // ---- Stage p1: E pipeline register ----
  always_ff @(posedge clk) begin
    if (w_load_bubble) begin
      r_e_icode_p1 <= I_NOP;
      r_e_ifun_p1  <= 4'd0;
      r_e_stat_p1  <= S_AOK;
      r_e_valc_p1  <= '0;
      r_e_vala_p1  <= '0;
      r_e_valb_p1  <= '0;
      r_e_dste_p1  <= R_NONE;
      r_e_dstm_p1  <= R_NONE;
    end else begin
      r_e_icode_p1 <= D_icode;
      r_e_ifun_p1  <= D_ifun;
      r_e_stat_p1  <= D_stat;
      r_e_valc_p1  <= D_valC;
      r_e_vala_p1  <= w_val_a;
      r_e_valb_p1  <= w_val_b;
      r_e_dste_p1  <= w_dec.dst_e;
      r_e_dstm_p1  <= w_dec.dst_m;
    end
  end

  assign E_icode = r_e_icode_p1;
  assign E_ifun  = r_e_ifun_p1;
  assign E_stat  = r_e_stat_p1;
  assign E_valC  = r_e_valc_p1;
  assign E_valA  = r_e_vala_p1;
  assign E_valB  = r_e_valb_p1;
  assign E_dstE  = r_e_dste_p1;
  assign E_dstM  = r_e_dstm_p1;

endmodule

// File: tb/tb_decode_regfile_stage.sv
// Directed bench for decode_regfile_stage: hand-computed expectations for reset,
// register-file reads, forwarding priority, load-use stall and bubble injection.
module tb_decode_regfile_stage;

  localparam int DATA_W = 64;

  logic              clk = 1'b0;
  logic              reset;
  logic [3:0]        D_icode, D_ifun, D_rA, D_rB;
  logic [2:0]        D_stat;
  logic [DATA_W-1:0] D_valC, D_valP;
  logic [3:0]        e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
  logic [DATA_W-1:0] e_valE, M_valE, m_valM, W_valE, W_valM;
  logic              E_bubble;
  logic              d_stall;
  logic [3:0]        E_icode, E_ifun, E_dstE, E_dstM;
  logic [2:0]        E_stat;
  logic [DATA_W-1:0] E_valC, E_valA, E_valB;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  decode_regfile_stage #(.DATA_W(DATA_W), .NUM_REG(15), .STACK_INIT(256)) dut (
    .clk(clk), .reset(reset),
    .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
    .D_stat(D_stat), .D_valC(D_valC), .D_valP(D_valP),
    .e_dstE(e_dstE), .e_valE(e_valE),
    .M_dstE(M_dstE), .M_valE(M_valE),
    .M_dstM(M_dstM), .m_valM(m_valM),
    .W_dstE(W_dstE), .W_valE(W_valE),
    .W_dstM(W_dstM), .W_valM(W_valM),
    .E_bubble(E_bubble), .d_stall(d_stall),
    .E_icode(E_icode), .E_ifun(E_ifun), .E_stat(E_stat),
    .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB),
    .E_dstE(E_dstE), .E_dstM(E_dstM)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    D_icode = 4'd1; D_ifun = 4'd0; D_rA = 4'hF; D_rB = 4'hF; D_stat = 3'd1;
    D_valC = '0; D_valP = '0;
    e_dstE = 4'hF; M_dstE = 4'hF; M_dstM = 4'hF; W_dstE = 4'hF; W_dstM = 4'hF;
    e_valE = '0; M_valE = '0; m_valM = '0; W_valE = '0; W_valM = '0;
    E_bubble = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic dec(input logic [3:0] icode, input logic [3:0] ra, input logic [3:0] rb);
    idle();
    D_icode = icode; D_rA = ra; D_rB = rb;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    step(); step();
    reset = 1'b0;
    chk("rst_icode", 64'(E_icode), 64'd1);
    chk("rst_ifun",  64'(E_ifun),  64'd0);
    chk("rst_stat",  64'(E_stat),  64'd1);
    chk("rst_dstE",  64'(E_dstE),  64'hF);
    chk("rst_dstM",  64'(E_dstM),  64'hF);
    chk("rst_valA",  E_valA, 64'd0);
    chk("rst_valB",  E_valB, 64'd0);
    chk("rst_valC",  E_valC, 64'd0);
    chk("rst_stall", 64'(d_stall), 64'd0);

    // pushq %rsp: both operands read reg 4
    dec(4'd10, 4'd4, 4'hF); step();
    chk("rsp_valA", E_valA, 64'd256);
    chk("rsp_valB", E_valB, 64'd256);
    chk("push_dstE", 64'(E_dstE), 64'd4);
    dec(4'd10, 4'd0, 4'hF); step();
    chk("r0_valA", E_valA, 64'd0);

    // write-back then read through the register file
    idle(); W_dstE = 4'd3; W_valE = 64'd7; step();
    dec(4'd2, 4'd3, 4'd5); step();
    chk("rf_wb_valA", E_valA, 64'd7);
    chk("rrmov_dstE", 64'(E_dstE), 64'd5);

    // forwarding priority
    dec(4'd6, 4'd1, 4'd0);
    e_dstE = 4'd1; e_valE = 64'd5; M_dstE = 4'd1; M_valE = 64'd9; step();
    chk("fwd_e_over_M", E_valA, 64'd5);
    chk("opq_valB", E_valB, 64'd0);
    dec(4'd6, 4'd1, 4'd0);
    M_dstE = 4'd1; M_valE = 64'd9; W_dstE = 4'd1; W_valE = 64'd3; step();
    chk("fwd_M_over_W", E_valA, 64'd9);
    dec(4'd4, 4'd8, 4'd2);
    M_dstM = 4'd2; m_valM = 64'h22; M_dstE = 4'd2; M_valE = 64'h33;
    W_dstM = 4'd8; W_valM = 64'h44; W_dstE = 4'd8; W_valE = 64'h55; step();
    chk("fwd_mM_over_ME", E_valB, 64'h22);
    chk("fwd_WM_over_WE", E_valA, 64'h44);

    // load-use stall on mrmovq
    dec(4'd5, 4'd2, 4'd0); step();
    chk("mrmov_icode", 64'(E_icode), 64'd5);
    chk("mrmov_dstM", 64'(E_dstM), 64'd2);
    dec(4'd6, 4'd2, 4'd3); #1;
    chk("lu_stall", 64'(d_stall), 64'd1);
    step();
    chk("lu_bubble_icode", 64'(E_icode), 64'd1);
    chk("lu_bubble_dstE", 64'(E_dstE), 64'hF);
    chk("lu_stall_clear", 64'(d_stall), 64'd0);
    dec(4'd6, 4'd2, 4'd3); M_dstM = 4'd2; m_valM = 64'h11; step();
    chk("lu_fwd_valM", E_valA, 64'h11);

    // same-index write-back: M wins; RNONE write changes nothing
    idle(); W_dstE = 4'd6; W_dstM = 4'd6; W_valE = 64'd1; W_valM = 64'd2; step();
    idle(); W_dstE = 4'hF; W_valE = 64'hDEAD; W_dstM = 4'hF; W_valM = 64'hBEEF; step();
    dec(4'd4, 4'd6, 4'd3); step();
    chk("wb_M_wins", E_valA, 64'd2);
    chk("wb_none_r3", E_valB, 64'd7);

    // bubble request vs call
    dec(4'd8, 4'hF, 4'hF); D_valP = 64'h40; E_bubble = 1'b1; step();
    chk("bub_icode", 64'(E_icode), 64'd1);
    chk("bub_valA", E_valA, 64'd0);
    dec(4'd8, 4'hF, 4'hF); D_valP = 64'h40; step();
    chk("call_valA", E_valA, 64'h40);
    chk("call_dstE", 64'(E_dstE), 64'd4);
    chk("call_valB", E_valB, 64'd256);

    // popq load-use and a non-matching successor
    dec(4'd11, 4'd7, 4'hF); step();
    chk("pop_dstM", 64'(E_dstM), 64'd7);
    chk("pop_valA", E_valA, 64'd256);
    dec(4'd2, 4'd6, 4'd1); #1;
    chk("pop_nostall", 64'(d_stall), 64'd0);
    dec(4'd2, 4'd7, 4'd1); #1;
    chk("pop_stall", 64'(d_stall), 64'd1);
    step();
    chk("pop_bubble", 64'(E_icode), 64'd1);

    // control/constant pass-through and unknown icode
    dec(4'd3, 4'hF, 4'd9); D_ifun = 4'd3; D_stat = 3'd2; D_valC = 64'h1234; step();
    chk("irmov_ifun", 64'(E_ifun), 64'd3);
    chk("irmov_stat", 64'(E_stat), 64'd2);
    chk("irmov_valC", E_valC, 64'h1234);
    chk("irmov_dstE", 64'(E_dstE), 64'd9);
    dec(4'hE, 4'd3, 4'd3); step();
    chk("bad_dstE", 64'(E_dstE), 64'hF);
    chk("bad_valA", E_valA, 64'd0);

    // reset beats a same-cycle write-back
    idle(); reset = 1'b1; W_dstE = 4'd4; W_valE = 64'd99; W_dstM = 4'd3; W_valM = 64'd99; step();
    reset = 1'b0;
    dec(4'd4, 4'd4, 4'd3); step();
    chk("rst_prio_r4", E_valA, 64'd256);
    chk("rst_prio_r3", E_valB, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/decode_regfile_stage.md
DECODE_REGFILE_STAGE -- requirements
Module: decode_regfile_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 64, register/datapath width.
REQ-002 SHALL have parameter NUM_REG, default 15, architectural registers; index 15 = RNONE (no register).
REQ-003 SHALL have parameter STACK_INIT, default 256, reset value of register 4 (rsp).
REQ-004 SHALL have ports: clk  in  1  clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 D_icode / D_ifun  in  4 / 4  decode-stage instruction code / function.
REQ-007 D_rA / D_rB  in  4 / 4  register specifiers.
REQ-008 D_stat  in  3  decode-stage status.
REQ-009 D_valC / D_valP  in  DATA_W / DATA_W  constant / next PC.
REQ-010 e_dstE, e_valE  in  4, DATA_W  execute forwarding source.
REQ-011 M_dstE, M_valE  in  4, DATA_W  memory-stage ALU forwarding source.
REQ-012 M_dstM, m_valM  in  4, DATA_W  memory-read forwarding source.
REQ-013 W_dstE, W_valE  in  4, DATA_W  write-back port E.
REQ-014 W_dstM, W_valM  in  4, DATA_W  write-back port M.
REQ-015 E_bubble  in  1  external bubble request (branch mispredict / ret).
REQ-016 d_stall  out  1  load-use stall to fetch and D register.
REQ-017 E_icode, E_ifun, E_stat  out  4, 4, 3  registered E-stage control.
REQ-018 E_valC, E_valA, E_valB  out  DATA_W each  registered E-stage operands.
REQ-019 E_dstE, E_dstM  out  4, 4  registered E-stage destinations.

Function
REQ-020 srcA/srcB/dstE/dstM SHALL decode per icode: 2 (rA,15,rB,15); 3 (15,15,rB,15); 4 (rA,rB,15,15); 5 (15,rB,15,rA); 6 (rA,rB,rB,15); 7 (15,15,15,15); 8 (15,4,4,15); 9 (4,4,4,15); 10 (rA,4,4,15); 11 (4,4,4,rA); all other icodes all 15.
REQ-021 Register file SHALL write W_valE to W_dstE and W_valM to W_dstM on the rising edge; index 15 never written; when W_dstE == W_dstM, W_valM SHALL win.
REQ-022 valA SHALL be D_valP for icode 7 or 8; else first match of srcA (srcA != 15) in priority e_dstE, M_dstM, M_dstE, W_dstM, W_dstE, yielding e_valE, m_valM, M_valE, W_valM, W_valE; else register-file read; srcA == 15 gives 0.
REQ-023 valB SHALL use the same priority chain on srcB without the valP override.
REQ-024 d_stall SHALL be combinational: 1 when E_icode in {5,11} and E_dstM != 15 and E_dstM equals srcA or srcB; else 0.
REQ-025 E register SHALL load a bubble when E_bubble or d_stall is 1, otherwise the decoded bundle, each rising edge; latency 1 cycle.
REQ-026 Bubble SHALL be E_icode=1, E_ifun=0, E_stat=1 (AOK), E_dstE=E_dstM=15, E_valC=E_valA=E_valB=0.
REQ-027 Arithmetic SHALL be pure selection; no width conversion; all values DATA_W bits, unsigned storage.

Reset
REQ-028 On reset SHALL set registers 0..14 to 0 except register 4 = STACK_INIT, and load the E register with the bubble of REQ-026; reset SHALL take priority over write-back in the same cycle; d_stall SHALL be 0 on the cycle after reset.

Structure
REQ-029 Icode constants (NOP=1..POPQ=11), RNONE=15, RSP=4, and stat codes SHALL live in the shared package y86_pkg; the register file SHALL be one sub-module regfile_2w2r (two write, two read ports).

Verification
REQ-030 After reset: the E outputs hold the bubble; a read of reg 4 returns 256; other registers return 0.
REQ-031 W_dstE=3, W_valE=7 for one cycle, then D_icode=2, D_rA=3 with no other forwarding -> E_valA=7 one cycle later.
REQ-032 e_dstE=1, e_valE=5 and M_dstE=1, M_valE=9 same cycle, D_icode=6, rA=1 -> E_valA=5.
REQ-033 E holds icode 5 with E_dstM=2, D_icode=6, rA=2 -> d_stall=1 and E_icode=1 on the next edge; then M_dstM=2, m_valM=0x11 -> E_valA=0x11.
REQ-034 W_dstE=W_dstM=6, W_valE=1, W_valM=2 -> reg 6 reads 2; W_dstE=15 -> no register changes.
REQ-035 E_bubble=1 with D_icode=8, D_valP=0x40 -> E_icode=1; with E_bubble=0 the same input -> E_valA=0x40, E_dstE=4.
